// File: rtl/tisc_pkg.sv
// Shared types and constants for the fetch stage and its prefetch FIFO.
package tisc_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;
    localparam int OPC_W   = 4;

    localparam logic [OPC_W-1:0] HALT_OPC = 4'hF;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        STOP  = 1'b1
    } fetch_state_t;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO of fetch entries; flush clears pointers and count
// and wins over push/pop. Simultaneous push+pop is supported at any occupancy.
module fetch_fifo
    import tisc_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       din,
    input  logic               pop,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    output logic               full
);

    fetch_entry_t       mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    // Storage is cleared on reset so the head reads as zero until the first write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push && !flush) begin
            mem_r[wr_ptr_r] <= din;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head and status decode from registered state.
    always_comb begin
        head  = mem_r[rd_ptr_r];
        count = count_r;
        empty = (count_r == CNT_W'(0));
        full  = (count_r == CNT_W'(DEPTH));
    end

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: owns the fetch PC, fills a prefetch FIFO and hands
// entries to decode. Optional halt-on-opcode behaviour is enabled by FETCH_HALT_EN.
module fetch_queue_stage
    import tisc_pkg::*;
#(
    parameter  int PC_W    = tisc_pkg::PC_W,
    parameter  int INSTR_W = tisc_pkg::INSTR_W,
    parameter  int DEPTH   = 4,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    out_pc_next,
    output logic [CNT_W-1:0]   fifo_count,
    output logic               halted
);

    logic [PC_W-1:0]  fetch_pc_r;
    logic             pop_s;
    logic             push_s;
    logic             fetch_en_s;
    logic             full_s;
    logic             empty_s;
    fetch_entry_t     wr_entry_s;
    fetch_entry_t     head_s;

`ifdef FETCH_HALT_EN
    fetch_state_t     state_r;
    logic             halted_r;
    logic             halt_hit_s;

    // Halt decode looks at the instruction being pushed this cycle.
    always_comb begin
        fetch_en_s = (state_r == FETCH);
        halt_hit_s = (opcode_of(imem_data) == HALT_OPC);
        halted     = halted_r;
    end
`else
    // Without the halt feature fetch is always enabled.
    always_comb begin
        fetch_en_s = 1'b1;
        halted     = 1'b0;
    end
`endif

    // Handshake and push gating; a redirect cycle never pushes.
    always_comb begin
        pop_s            = !empty_s && out_ready;
        push_s           = fetch_en_s && !redirect_valid && (!full_s || pop_s);
        wr_entry_s.pc    = fetch_pc_r;
        wr_entry_s.instr = imem_data;
    end

    // Fetch PC and FETCH/STOP control; redirect beats push, reset beats all.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= '0;
`ifdef FETCH_HALT_EN
            state_r    <= FETCH;
            halted_r   <= 1'b0;
`endif
        end else if (redirect_valid) begin
            fetch_pc_r <= redirect_pc;
`ifdef FETCH_HALT_EN
            state_r    <= FETCH;
            halted_r   <= 1'b0;
`endif
        end else if (push_s) begin
            fetch_pc_r <= fetch_pc_r + PC_W'(1);
`ifdef FETCH_HALT_EN
            state_r    <= halt_hit_s ? STOP : FETCH;
            halted_r   <= halt_hit_s;
`endif
        end else begin
            fetch_pc_r <= fetch_pc_r;
`ifdef FETCH_HALT_EN
            state_r    <= state_r;
            halted_r   <= halted_r;
`endif
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push_s),
        .din   (wr_entry_s),
        .pop   (pop_s),
        .head  (head_s),
        .count (fifo_count),
        .empty (empty_s),
        .full  (full_s)
    );

    // Output decode; all sources are registers.
    always_comb begin
        imem_addr   = fetch_pc_r;
        out_valid   = !empty_s;
        out_instr   = head_s.instr;
        out_pc      = head_s.pc;
        out_pc_next = head_s.pc + PC_W'(1);
    end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
- Instruction-fetch stage directly upstream of the pipelined datapath.
- Owns the fetch PC and drives the combinational program-memory read address.
- Buffers fetched {pc, instr} pairs in a small prefetch queue and presents them to decode with a valid/ready handshake.
- Accepts a PC redirect from the writeback stage, which flushes the queue and restarts fetch.

Parameters:
- PC_W, 8, fetch PC and memory address width.
- INSTR_W, 16, instruction width; opcode is bits [INSTR_W-1:INSTR_W-4].
- DEPTH, 4, prefetch queue entries; must be a power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  PC_W  program-memory read address; always equals fetch_pc.
- imem_data  in  INSTR_W  program-memory read data; combinational from imem_addr, same cycle.
- redirect_valid  in  1  load redirect_pc and flush.
- redirect_pc  in  PC_W  new fetch PC.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  INSTR_W  head instruction.
- out_pc  out  PC_W  head instruction's PC.
- out_pc_next  out  PC_W  out_pc+1, mod 2^PC_W.
- fifo_count  out  $clog2(DEPTH+1)  occupied entries.
- halted  out  1  fetch stopped on HALT (see Optional Feature).

Behaviour:
- Reset, synchronous and active-high: fetch_pc=0, count=0, rd/wr pointers=0, out_valid=0, out_instr=0, out_pc=0, halted=0. Reset beats every other input.
- pop = out_valid && out_ready.
- push = !halted && (count<DEPTH || pop); push writes {fetch_pc, imem_data}, and fetch_pc advances by 1 modulo 2^PC_W (0xFF→0x00).
- Push and pop in the same cycle when full is legal; count stays at DEPTH.
- Push and pop in the same cycle when empty is not a bypass: the entry lands in the queue; out_valid rises the next cycle.
- Fetch-to-output latency: instruction fetched in cycle N is visible at out_* in cycle N+1 at the earliest. Queue storage is registered.
- out_valid = (count!=0). out_instr/out_pc reflect the head entry and hold stable while out_valid && !out_ready.
- Redirect has priority over push and pop:
  - the cycle redirect_valid=1 does not push;
  - count, rd_ptr and wr_ptr clear to 0;
  - fetch_pc<=redirect_pc;
  - halted<=0.
  - A head shown during the redirect cycle is discarded even if out_ready=1. The consumer must squash it.
  - Next cycle, fetch resumes from redirect_pc; out_valid=0 in that cycle.
- Redirect in the cycle immediately after reset is honoured normally.
- Control is two-state, FETCH and STOP; STOP exists only with the halt feature. Redirect moves to FETCH from either state.

Optional Feature:
- Macro FETCH_HALT_EN.
- Defined:
  - A pushed instruction with opcode == HALT_OPC (4'hF) is enqueued normally, and halted<=1 at the end of that cycle.
  - No further pushes happen; fetch_pc holds at HALT address+1.
  - The queue drains normally.
  - Only redirect or rst clears halted.
- Undefined: halted is tied 0, the state machine has only FETCH, and opcode 4'hF is fetched like any other instruction.

Decomposition:
- Shared package tisc_pkg holds:
  - PC_W and INSTR_W defaults;
  - OPC_W=4 and HALT_OPC=4'hF;
  - typedef fetch_entry_t {logic [PC_W-1:0] pc; logic [INSTR_W-1:0] instr;}.
- One sub-module, fetch_fifo: synchronous circular FIFO of fetch_entry_t with push, pop, flush, count, head outputs and simultaneous push+pop support.
- Top level holds fetch_pc, the push gating and the halt state machine.

Test Plan:
- Reset release, out_ready=1, imem returns 16'h1000+addr → out_pc 0,1,2,… on consecutive cycles; first out_valid one cycle after the first fetch; out_instr=16'h1000+out_pc.
- out_ready=0 for 10 cycles from reset → fifo_count saturates at 4; imem_addr holds at 4; out_pc stays 0. Raise out_ready → PCs 0..7 delivered with no gap or duplicate.
- Wrap: redirect_pc=8'hFE → delivered PCs FE, FF, 00, 01; out_pc_next for FF is 00.
- Queue full at count=4 with out_pc=8'h10, redirect_valid=1, redirect_pc=8'h40 → next cycle count=0 and out_valid=0; following cycle out_pc=8'h40 with out_valid=1; no 8'h11..8'h13 ever shown.
- FETCH_HALT_EN defined, imem[3]=16'hF000 → PCs 0..3 delivered; halted=1; imem_addr stuck at 4; out_valid drops after PC 3 pops. Redirect to 8'h20 → halted=0 and fetch resumes at 8'h20.
- rst asserted mid-stream with count=3 → next cycle count=0, out_valid=0, imem_addr=0, halted=0.
